spi_rx_peripheral: RTL
======================

Name: spi_rx_peripheral

Overview:
Memory-mapped SPI target-side receiver, the receive counterpart to the team's TX-only SPI controller peripheral. It samples externally driven SCLK/MOSI/CS_N, assembles bytes (mode 0: sample on SCLK rising edge, MSB first), and buffers them in an RX FIFO. The processor reads the FIFO and status through the same 32-bit registered mem bus used by the other peripherals.

Parameters:
FIFO_AW, 4, log2 of FIFO depth (16 entries); pointers are FIFO_AW+1 bits wide.
D_ENABLE, 1'b1, reset value of the CONTROL.enable bit.

Ports:
clk  input  1  system clock
rst  input  1  reset: synchronous, active-high
SCLK  input  1  external SPI clock, asynchronous to clk
MOSI  input  1  external serial data, asynchronous to clk
CS_N  input  1  external chip select, active-low, asynchronous to clk
mem_addr  input  32  byte address; only [3:0] are decoded
mem_rmask  input  4  read byte mask; nonzero means read request
mem_wmask  input  4  write byte mask; nonzero means write request
mem_wdata  input  32  write data
mem_rdata  output  32  registered read data
mem_resp  output  1  registered response, one cycle after any request

Behaviour:
- Input sync: SCLK, MOSI and CS_N each pass through a 2-flop synchronizer. Reset values are SCLK=0, MOSI=0, CS_N=1. A third SCLK flop provides edge detection.
- Timing requirement: SCLK high and low phases are each at least 3 clk periods. Latency from the 8th SCLK rising pin edge to the byte being readable is at most 4 clk.
- FSM has two states:
  - IDLE: synced CS_N=1 or enable=0. Bit counter held at 0.
  - ACTIVE: synced CS_N=0 and enable=1.
  - IDLE->ACTIVE on CS_N falling. ACTIVE->IDLE on CS_N rising or enable cleared.
- ACTIVE, synced SCLK rising edge:
  - Shift synced MOSI into an 8-bit shift register at bit 0, shifting left.
  - Increment the 3-bit bit counter.
  - On count wrap 7->0, push the assembled byte.
- Push rules:
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, the sticky overflow flag is set, and ovf_count (8-bit) increments, saturating at 255.
- Frame abort: a CS_N rising edge while the bit counter is nonzero discards the partial byte, sets the sticky frame_err flag and clears the counter. No push occurs.
- FIFO pointers:
  - empty when wptr == rptr.
  - full when MSBs differ and low FIFO_AW bits are equal.
  - Pointers wrap naturally.
- Register map, decoded on mem_addr[3:0]:
  - 0x0 RX_DATA, read-only. Returns {23'b0, valid, data[7:0]}. If not empty: valid=1, head byte is returned and popped. If empty: returns 0 and no pop. Writes are ignored.
  - 0x4 STATUS, read-only. Fields: [4:0] rptr, [12:8] wptr, [16] empty, [17] full, [18] overflow, [19] frame_err, [31:24] ovf_count. All other bits read 0.
  - 0x8 CONTROL.
    - Write with wmask[0]: bit0 enable; bit1 flush (self-clearing, sets rptr=wptr=0); bit2 clear (clears overflow, frame_err and ovf_count).
    - Read returns {31'b0, enable}.
  - 0xC and any unaligned offset: reads return 0, writes are ignored.
- Simultaneous events:
  - Flush and push in the same cycle: flush wins, the byte is lost, overflow is not flagged.
  - Clear and a new overflow in the same cycle: the new event wins (flag=1, ovf_count=1).
  - Pop and push in the same cycle when full: both occur, so the FIFO stays full with no overflow.
- Mem bus:
  - mem_resp_next = |{mem_rmask, mem_wmask}. Read data is registered and returned with resp; side effects (pop, control write) take effect on the request cycle.
  - mem_rdata = 0 on any cycle without a read response.
- Reset values: mem_resp=0, mem_rdata=0, pointers=0, flags=0, ovf_count=0, bit counter=0, shift register=0, enable=D_ENABLE, FSM=IDLE.
- Reset during a frame aborts it silently: no frame_err, and FIFO contents are lost.

Optional Feature:
- Macro: SPI_RX_LSB_FIRST_EN.
- Defined: bytes are received LSB first. The shift register shifts right and inserts MOSI at bit 7. STATUS[20] reads 1.
- Not defined: MSB first as described above. STATUS[20] reads 0.
- All other behaviour is identical.

Test Plan:
- Reset, then CS_N low and send 0xA5 MSB-first, then CS_N high -> STATUS empty=0, wptr=1; read 0x0 returns 0x1A5; next STATUS read shows empty=1, rptr=1.
- Read 0x0 with FIFO empty -> mem_rdata=0x000, mem_resp=1 exactly one cycle later, pointers unchanged.
- Send 18 bytes 0x00..0x11 without reads -> full=1, overflow=1, ovf_count=2; 16 reads return 0x00..0x0F in order; write CONTROL=0x5 -> overflow=0, ovf_count=0.
- Send 5 bits then raise CS_N, then send full byte 0x3C -> frame_err=1, a single FIFO entry reading 0x13C.
- Write CONTROL=0x0, then send byte 0x77 -> nothing pushed; write CONTROL=0x3 with 2 bytes queued -> rptr=wptr=0, empty=1, enable=1.
- With SPI_RX_LSB_FIRST_EN defined, send bit sequence 1,0,0,0,0,0,0,0 -> RX_DATA returns 0x101, STATUS[20]=1.

Source files
------------

// File: rtl/spi_rx_peripheral.sv
// -----------------------------------------------------------------------------
// spi_rx_peripheral
//
// SPI target-side receiver (mode 0) with an RX FIFO behind the 32-bit
// registered mem bus. SCLK/MOSI/CS_N are synchronized into clk, bytes are
// assembled on synced SCLK rising edges and pushed into the FIFO.
//
// Optional build macro: SPI_RX_LSB_FIRST_EN
//   defined     -> bytes received LSB first, STATUS[20] reads 1
//   not defined -> bytes received MSB first, STATUS[20] reads 0
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   SCLK       external SPI clock (asynchronous)
//   MOSI       external serial data (asynchronous)
//   CS_N       external active-low chip select (asynchronous)
//   mem_addr   byte address, [3:0] decoded
//   mem_rmask  read byte mask, nonzero = read request
//   mem_wmask  write byte mask, nonzero = write request
//   mem_wdata  write data
//   mem_rdata  registered read data (0 when no read response)
//   mem_resp   registered response, one cycle after any request
//
// Register map (mem_addr[3:0]):
//   0x0 RX_DATA  {23'b0, valid, data}; reading pops when not empty
//   0x4 STATUS   [4:0] rptr, [12:8] wptr, [16] empty, [17] full,
//                [18] overflow, [19] frame_err, [20] lsb_first, [31:24] ovf_count
//   0x8 CONTROL  write: bit0 enable, bit1 flush, bit2 clear; read {31'b0, enable}
// -----------------------------------------------------------------------------
module spi_rx_peripheral #(
    parameter int   FIFO_AW  = 4,
    parameter logic D_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS_N,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_rmask,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Synchronizers; the third stage of SCLK and CS_N holds the previous
    // synced value for edge detection.
    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;
    logic csn_s1, csn_s2, csn_s3;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_q;
    logic [7:0]      byte_next;
    logic [7:0]      fifo_mem [DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic            enable;
    logic            overflow, frame_err;
    logic [7:0]      ovf_count;

    logic            sclk_rise, cs_fall;
    logic            shift_en, frame_abort;
    logic            rd_req, wr_req, ctrl_wr, flush, clr, pop;
    logic            empty, full;
    logic            push_req, push_ok, ovf_evt;
    logic [31:0]     status, rdata_d;
    logic            lsb_first;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign cs_fall   = csn_s3 & ~csn_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            csn_s1  <= 1'b1;
            csn_s2  <= 1'b1;
            csn_s3  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, which is what forms a shift chain.
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
            csn_s1  <= CS_N;
            csn_s2  <= csn_s1;
            csn_s3  <= csn_s2;
        end
    end

    // Bus decode; side effects act on the request cycle.
    assign rd_req  = |mem_rmask;
    assign wr_req  = |mem_wmask;
    assign ctrl_wr = wr_req && (mem_addr[3:0] == 4'h8) && mem_wmask[0];
    assign flush   = ctrl_wr && mem_wdata[1];
    assign clr     = ctrl_wr && mem_wdata[2];

    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign pop   = rd_req && (mem_addr[3:0] == 4'h0) && !empty;

`ifdef SPI_RX_LSB_FIRST_EN
    assign byte_next = {mosi_s2, shift_q[7:1]};
    assign lsb_first = 1'b1;
`else
    assign byte_next = {shift_q[6:0], mosi_s2};
    assign lsb_first = 1'b0;
`endif

    // FSM next state and per-cycle strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        shift_en    = 1'b0;
        frame_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall && enable) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (csn_s2 || !enable) begin
                    state_d     = IDLE;
                    // Only a CS_N rise mid-byte is a framing error; disabling
                    // the receiver discards the partial byte silently.
                    frame_abort = csn_s2 && (bit_cnt != 3'd0);
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush wins over a concurrent push; a pop frees a slot in the same cycle.
    assign push_req = shift_en && (bit_cnt == 3'd7);
    assign push_ok  = push_req && (!full || pop) && !flush;
    assign ovf_evt  = push_req && full && !pop && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt   <= 3'd0;
            shift_q   <= 8'd0;
            wptr      <= '0;
            rptr      <= '0;
            enable    <= D_ENABLE;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            ovf_count <= 8'd0;
            mem_resp  <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            state_q <= state_d;

            if (state_d == IDLE) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift_q <= byte_next;
            end

            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push_ok) wptr <= wptr + PW'(1);
                if (pop)     rptr <= rptr + PW'(1);
            end

            if (ctrl_wr) enable <= mem_wdata[0];

            // A new event in the same cycle as clear takes priority.
            if (ovf_evt) begin
                overflow  <= 1'b1;
                ovf_count <= clr ? 8'd1 :
                             (ovf_count == 8'hFF) ? 8'hFF : ovf_count + 8'd1;
            end else if (clr) begin
                overflow  <= 1'b0;
                ovf_count <= 8'd0;
            end

            if (frame_abort)  frame_err <= 1'b1;
            else if (clr)     frame_err <= 1'b0;

            mem_resp  <= rd_req | wr_req;
            mem_rdata <= rdata_d;
        end
    end

    // NOTE: the FIFO storage has no reset; only the pointers define which
    // entries are valid, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wptr[FIFO_AW-1:0]] <= byte_next;
    end

    always_comb begin
        status                   = 32'd0;
        status[FIFO_AW:0]        = rptr;
        status[8 +: PW]          = wptr;
        status[16]               = empty;
        status[17]               = full;
        status[18]               = overflow;
        status[19]               = frame_err;
        status[20]               = lsb_first;
        status[31:24]            = ovf_count;
    end

    always_comb begin
        rdata_d = 32'd0;
        if (rd_req) begin
            case (mem_addr[3:0])
                4'h0:    rdata_d = empty ? 32'd0 : {23'd0, 1'b1, fifo_mem[rptr[FIFO_AW-1:0]]};
                4'h4:    rdata_d = status;
                4'h8:    rdata_d = {31'd0, enable};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // Address and data bits outside the decoded fields are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[31:4], mem_wdata[31:3]};

endmodule
